// File: rtl/ser_deser_arbiter_pkg.sv
// Shared types and default sizing for the serial-to-parallel arbiter.
package ser_deser_arb_pkg;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_WIDTH   = 8;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/ser_deser_arbiter_rr_picker.sv
// Round-robin picker: first set request at or after rr_ptr, wrapping.
// Purely combinational; rr_ptr is expected to stay below N_REQ.
module rr_picker
  import ser_deser_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    rr_ptr,
  output logic [N_REQ-1:0] pick,
  output logic [IW-1:0]    pick_idx
);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;
  logic          found;

  // Scan lanes starting at the pointer; the first pending one wins.
  always_comb begin
    sum      = '0;
    cand     = '0;
    found    = 1'b0;
    pick_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(N_REQ)) sum = sum - (IW+1)'(N_REQ);
      cand = sum[IW-1:0];
      if (!found && req[cand]) begin
        found    = 1'b1;
        pick_idx = cand;
      end
    end
    pick = found ? (N_REQ'(1) << pick_idx) : '0;
  end

endmodule

// File: rtl/ser_deser_arbiter.sv
// Arbitrates N_REQ serial lanes, deserializes WIDTH bits MSB-first from the
// granted lane and presents the word with a one-cycle parallel_valid pulse.
// Optional idle-bit watchdog: define SER_DESER_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no owner; arbitrate pending requests, grant takes effect next cycle
// SHIFT | lane owns the bus; accept bits until WIDTH collected or req drops
// DONE  | word presented; rr_ptr already advanced, so arbitration for the
//       | next word happens here to keep the k+2 grant latency
module ser_deser_arbiter
  import ser_deser_arb_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         serial_valid,
  input  logic [N_REQ-1:0]         serial_data,
  output logic [N_REQ-1:0]         gnt,
  output logic                     parallel_valid,
  output logic [WIDTH-1:0]         parallel_data,
  output logic [$clog2(N_REQ)-1:0] parallel_src,
  output logic                     timeout_err
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(WIDTH);

  arb_state_t       state, state_n;
  logic [N_REQ-1:0] gnt_n;
  logic [IW-1:0]    rr_ptr, ptr_n;
  logic [IW-1:0]    own_idx, own_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] shreg, shreg_n, shifted;
  logic             pv_n;
  logic [WIDTH-1:0] pd_n;
  logic [IW-1:0]    ps_n;
  logic [N_REQ-1:0] pick;
  logic [IW-1:0]    pick_idx;
  logic             accept, bit_in, last_bit, wd_fire;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
    return (i == IW'(N_REQ-1)) ? '0 : i + IW'(1);
  endfunction

  rr_picker #(.N_REQ(N_REQ), .IW(IW)) u_picker (
    .req      (req),
    .rr_ptr   (rr_ptr),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  // gnt is one-hot, so masking selects exactly the owner's strobe and bit.
  assign accept   = |(gnt & serial_valid);
  assign bit_in   = |(gnt & serial_data);
  assign shifted  = {shreg[WIDTH-2:0], bit_in};
  assign last_bit = accept && (cnt == CW'(WIDTH-1));

`ifdef SER_DESER_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT+1);
  logic [TW-1:0] wd_cnt;

  assign wd_fire = (state == SHIFT) && !accept && (wd_cnt == TW'(TIMEOUT-1));

  // Watchdog counts owned cycles without a bit and pulses on expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= wd_fire && !last_bit;
      if (state != SHIFT || accept || wd_fire) wd_cnt <= '0;
      else                                     wd_cnt <= wd_cnt + TW'(1);
    end
  end
`else
  assign wd_fire     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Next-state, grant and datapath decisions.
  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    ptr_n   = rr_ptr;
    own_n   = own_idx;
    cnt_n   = cnt;
    shreg_n = shreg;
    pv_n    = 1'b0;
    pd_n    = parallel_data;
    ps_n    = parallel_src;
    case (state)
      IDLE, DONE: begin
        state_n = IDLE;
        gnt_n   = '0;
        cnt_n   = '0;
        if (|req) begin
          state_n = SHIFT;
          gnt_n   = pick;
          own_n   = pick_idx;
          shreg_n = '0;
        end
      end
      SHIFT: begin
        if (accept) begin
          shreg_n = shifted;
          cnt_n   = cnt + CW'(1);
        end
        // The final bit takes priority over a simultaneous req drop or expiry.
        if (last_bit) begin
          state_n = DONE;
          gnt_n   = '0;
          cnt_n   = '0;
          pv_n    = 1'b1;
          pd_n    = shifted;
          ps_n    = own_idx;
          ptr_n   = wrap_inc(own_idx);
        end else if (!req[own_idx] || wd_fire) begin
          state_n = IDLE;
          gnt_n   = '0;
          cnt_n   = '0;
          ptr_n   = wrap_inc(own_idx);
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        cnt_n   = '0;
      end
    endcase
  end

  // State, grant and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      gnt            <= '0;
      rr_ptr         <= '0;
      own_idx        <= '0;
      cnt            <= '0;
      shreg          <= '0;
      parallel_valid <= 1'b0;
      parallel_data  <= '0;
      parallel_src   <= '0;
    end else begin
      state          <= state_n;
      gnt            <= gnt_n;
      rr_ptr         <= ptr_n;
      own_idx        <= own_n;
      cnt            <= cnt_n;
      shreg          <= shreg_n;
      parallel_valid <= pv_n;
      parallel_data  <= pd_n;
      parallel_src   <= ps_n;
    end
  end

endmodule
